dsp48a1_mac_sequencer: RTL and testbench

Controller that runs multiply-accumulate jobs on one DSP48A1 slice instance (A/B input regs, M reg, P reg, OPMODEREG=0). It accepts a job length, streams operand samples through a valid/ready handshake, and drives the slice's per-stage clock enables and OPMODE so that P = Σ(A·B) over the job. It then presents the result with a result handshake. It sits between the sample source and the slice; operand data goes directly to the slice, and only control passes through this block.

---
 rtl/dsp48a1_pkg.sv | 27 ++
 rtl/dsp48a1_mac_sequencer_tracker.sv | 34 +++
 rtl/dsp48a1_mac_sequencer.sv | 123 ++++++++++++
 tb/tb_dsp48a1_mac_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp48a1_pkg.sv
// Shared constants for the DSP48A1 MAC sequencer: FSM states, OPMODE fields and pipeline depth.
package dsp48a1_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLoad  = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    // Slice stages after the A/B input registers: M reg, then P reg.
    localparam int unsigned PIPE_DEPTH = 2;

    localparam logic [1:0]  OPMODE_X_M          = 2'b01;
    localparam logic [1:0]  OPMODE_Z_ZERO       = 2'b00;
    localparam logic [1:0]  OPMODE_Z_P          = 2'b10;
    localparam int unsigned OPMODE_POST_SUB_BIT = 7;

    // First product loads P (Z=0); later ones fold into P, optionally subtracting.
    function automatic logic [7:0] opmode_for(input logic first, input logic post_sub);
        logic [7:0] op;
        op = '0;
        op[1:0] = OPMODE_X_M;
        op[3:2] = first ? OPMODE_Z_ZERO : OPMODE_Z_P;
        op[OPMODE_POST_SUB_BIT] = ~first & post_sub;
        return op;
    endfunction

endpackage

// File: rtl/dsp48a1_mac_sequencer_tracker.sv
// dsp_pipe_tracker: shifts a valid bit and first-sample flag alongside the slice's
// post-input pipeline so each stage's clock enable fires only for real samples.
module dsp_pipe_tracker #(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_first,
    output logic [DEPTH-1:0] stage_valid,
    output logic             out_first
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] first_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            first_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            first_q[0] <= in_valid & in_first;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                first_q[i] <= first_q[i-1];
            end
        end
    end

    assign stage_valid = valid_q;
    assign out_first   = first_q[DEPTH-1];

endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// Control-only sequencer for one DSP48A1 slice: accepts samples, drives per-stage CEs and
// OPMODE so P accumulates sum(A*B), then hands the result over with res_valid/res_ready.
module dsp48a1_mac_sequencer
    import dsp48a1_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter bit          POST_SUB = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ce_ab,
    output logic             ce_m,
    output logic             ce_p,
    output logic [7:0]       opmode,
    output logic             p_clr,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             res_valid,
    input  logic             res_ready
);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      len_q, len_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  p_clr_q, p_clr_d;
    logic                  accept;
    logic                  last_accept;
    logic                  drain_done;
    logic                  out_first;
    logic [PIPE_DEPTH-1:0] stage_valid;

    assign in_ready    = (state_q == StLoad) && (cnt_q < len_q);
    assign accept      = in_valid & in_ready;
    assign last_accept = accept && ((cnt_q + CNT_W'(1)) == len_q);
    // Leave DRAIN once only the P stage (or nothing) is still in flight.
    assign drain_done  = (stage_valid[PIPE_DEPTH-2:0] == '0);

    dsp_pipe_tracker #(
        .DEPTH(PIPE_DEPTH)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (accept),
        .in_first   (cnt_q == '0),
        .stage_valid(stage_valid),
        .out_first  (out_first)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        p_clr_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    len_d = len;
                    cnt_d = '0;
                    if (len != '0) begin
                        state_d = StLoad;
                    end else begin
                        // Empty job: clear P, then pass through DRAIN so res_valid lands one cycle later.
                        p_clr_d = 1'b1;
                        state_d = StDrain;
                    end
                end
            end
            StLoad: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (last_accept) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (drain_done) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            cnt_q   <= '0;
            p_clr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            p_clr_q <= p_clr_d;
        end
    end

    always_comb begin
        opmode = '0;
        if (stage_valid[PIPE_DEPTH-1]) begin
            opmode = opmode_for(out_first, POST_SUB);
        end
    end

    assign busy       = (state_q != StIdle);
    assign res_valid  = (state_q == StDone);
    assign ce_ab      = accept;
    assign ce_m       = stage_valid[0];
    assign ce_p       = stage_valid[PIPE_DEPTH-1];
    assign p_clr      = p_clr_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Bench: two sequencers (add and subtract accumulate) share stimulus; each drives a simple
// behavioural slice model, and results are compared with sums of the offered products.
module tb_dsp48a1_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic        in_valid = 1'b0;
    logic        res_ready = 1'b0;
    logic [17:0] a_in = '0;
    logic [17:0] b_in = '0;

    logic        busy[2], in_ready[2], ce_ab[2], ce_m[2], ce_p[2], p_clr[2], res_valid[2];
    logic [7:0]  opmode[2];
    logic [15:0] sample_cnt[2];

    logic [17:0] a1[2], b1[2];
    logic [35:0] m_reg[2];
    logic [47:0] p_reg[2];

    int total = 0;
    int bad = 0;

    logic [17:0] ops_a[16];
    logic [17:0] ops_b[16];
    int          obs_ce_ab, obs_ce_m, obs_ce_p, obs_pclr_cnt, obs_pclr_cyc;
    int          obs_last_acc, obs_res_cyc;
    bit          obs_timeout;
    logic [7:0]  obs_op0[$], obs_op1[$];
    logic [47:0] obs_p0, obs_p1;

    always #5 clk = ~clk;

    dsp48a1_mac_sequencer #(.CNT_W(16), .POST_SUB(1'b0)) dut_add (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy[0]),
        .in_valid(in_valid), .in_ready(in_ready[0]), .ce_ab(ce_ab[0]), .ce_m(ce_m[0]),
        .ce_p(ce_p[0]), .opmode(opmode[0]), .p_clr(p_clr[0]), .sample_cnt(sample_cnt[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready)
    );

    dsp48a1_mac_sequencer #(.CNT_W(16), .POST_SUB(1'b1)) dut_sub (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy[1]),
        .in_valid(in_valid), .in_ready(in_ready[1]), .ce_ab(ce_ab[1]), .ce_m(ce_m[1]),
        .ce_p(ce_p[1]), .opmode(opmode[1]), .p_clr(p_clr[1]), .sample_cnt(sample_cnt[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready)
    );

    // Behavioural DSP48A1 slice: A1/B1 -> M -> P, OPMODE applied at the P stage.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ce_ab[k]) begin
                a1[k] <= a_in;
                b1[k] <= b_in;
            end
            if (ce_m[k]) m_reg[k] <= 36'(a1[k]) * 36'(b1[k]);
            if (p_clr[k]) p_reg[k] <= '0;
            else if (ce_p[k]) begin
                if (opmode[k][3:2] == 2'b00) p_reg[k] <= 48'(m_reg[k]);
                else if (opmode[k][7])       p_reg[k] <= p_reg[k] - 48'(m_reg[k]);
                else                         p_reg[k] <= p_reg[k] + 48'(m_reg[k]);
            end
        end
    end

    // Start a job in cycle 0 and feed ops_* with `gap` idle cycles between accepts,
    // recording observations until res_valid (cycle numbers relative to the start cycle).
    task automatic run_job(input int n, input int gap);
        int idx, wait_cnt, cyc;
        bit got;
        obs_op0.delete();
        obs_op1.delete();
        obs_ce_ab = 0; obs_ce_m = 0; obs_ce_p = 0; obs_pclr_cnt = 0; obs_pclr_cyc = -1;
        obs_last_acc = -1; obs_res_cyc = -1; obs_timeout = 0;
        idx = 0; wait_cnt = 0; got = 0; cyc = 0;
        @(negedge clk);
        start = 1'b1; len = 16'(n);
        in_valid = 1'b1; a_in = 18'h3ffff; b_in = 18'h3ffff;  // must be ignored outside LOAD
        #1;
        if (ce_ab[0]) obs_ce_ab++;
        while (!got && cyc < 300) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (idx < n && wait_cnt == 0) begin
                in_valid = 1'b1; a_in = ops_a[idx]; b_in = ops_b[idx];
            end else begin
                in_valid = 1'b0; a_in = 18'($urandom); b_in = 18'($urandom);
            end
            #1;
            if (in_valid && in_ready[0]) begin
                idx++; wait_cnt = gap; obs_last_acc = cyc;
            end else if (!in_valid && wait_cnt > 0) begin
                wait_cnt--;
            end
            if (ce_ab[0]) obs_ce_ab++;
            if (ce_m[0]) obs_ce_m++;
            if (ce_p[0]) begin obs_ce_p++; obs_op0.push_back(opmode[0]); end
            if (ce_p[1]) obs_op1.push_back(opmode[1]);
            if (p_clr[0]) begin obs_pclr_cnt++; obs_pclr_cyc = cyc; end
            if (res_valid[0]) begin
                got = 1; obs_res_cyc = cyc; obs_p0 = p_reg[0]; obs_p1 = p_reg[1];
            end
        end
        in_valid = 1'b0;
        if (!got) obs_timeout = 1;
    endtask

    task automatic ack_result();
        @(negedge clk); res_ready = 1'b1;
        @(negedge clk); res_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        start = 1'b1; in_valid = 1'b1; len = 16'd5;
        #23;
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy[0]); end
        total++; if (in_ready[0] !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b expected 0", in_ready[0]); end
        total++; if (ce_ab[0] !== 1'b0) begin bad++; $display("FAIL reset_ce_ab: got %b expected 0", ce_ab[0]); end
        total++; if (ce_m[0] !== 1'b0) begin bad++; $display("FAIL reset_ce_m: got %b expected 0", ce_m[0]); end
        total++; if (ce_p[0] !== 1'b0) begin bad++; $display("FAIL reset_ce_p: got %b expected 0", ce_p[0]); end
        total++; if (opmode[0] !== 8'h00) begin bad++; $display("FAIL reset_opmode: got %h expected 00", opmode[0]); end
        total++; if (p_clr[0] !== 1'b0) begin bad++; $display("FAIL reset_p_clr: got %b expected 0", p_clr[0]); end
        total++; if (sample_cnt[0] !== 16'd0) begin bad++; $display("FAIL reset_sample_cnt: got %0d expected 0", sample_cnt[0]); end
        total++; if (res_valid[0] !== 1'b0) begin bad++; $display("FAIL reset_res_valid: got %b expected 0", res_valid[0]); end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_basic();
        ops_a[0] = 18'd1; ops_b[0] = 18'd3;
        ops_a[1] = 18'd5; ops_b[1] = 18'd1;
        ops_a[2] = 18'd7; ops_b[2] = 18'd1;
        ops_a[3] = 18'd3; ops_b[3] = 18'd3;
        run_job(4, 0);
        total++; if (obs_timeout) begin bad++; $display("FAIL basic_timeout: got no res_valid expected res_valid"); end
        total++; if (obs_ce_ab != 4) begin bad++; $display("FAIL basic_ce_ab: got %0d expected 4", obs_ce_ab); end
        total++; if (obs_ce_p != 4) begin bad++; $display("FAIL basic_ce_p: got %0d expected 4", obs_ce_p); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e0, e1;
            e0 = (i == 0) ? 8'h01 : 8'h09;
            e1 = (i == 0) ? 8'h01 : 8'h89;
            total++; if (i >= obs_op0.size() || obs_op0[i] !== e0) begin
                bad++; $display("FAIL basic_opmode[%0d]: got %h expected %h", i, (i < obs_op0.size()) ? obs_op0[i] : 8'hxx, e0);
            end
            total++; if (i >= obs_op1.size() || obs_op1[i] !== e1) begin
                bad++; $display("FAIL basic_opmode_sub[%0d]: got %h expected %h", i, (i < obs_op1.size()) ? obs_op1[i] : 8'hxx, e1);
            end
        end
        total++; if (obs_res_cyc - obs_last_acc != 3) begin bad++; $display("FAIL basic_latency: got %0d expected 3", obs_res_cyc - obs_last_acc); end
        total++; if (obs_p0 !== 48'd24) begin bad++; $display("FAIL basic_p: got %0d expected 24", obs_p0); end
        total++; if (obs_p1 !== 48'(-18)) begin bad++; $display("FAIL basic_p_sub: got %h expected %h", obs_p1, 48'(-18)); end
        ack_result();
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b expected 0", busy[0]); end
        total++; if (sample_cnt[0] !== 16'd4) begin bad++; $display("FAIL basic_sample_cnt: got %0d expected 4", sample_cnt[0]); end
    endtask

    task automatic test_bubbles();
        logic [47:0] exp0;
        exp0 = '0;
        for (int i = 0; i < 3; i++) begin
            ops_a[i] = 18'($urandom_range(1, 2000));
            ops_b[i] = 18'($urandom_range(1, 2000));
            exp0 += 48'(ops_a[i]) * 48'(ops_b[i]);
        end
        run_job(3, 2);
        total++; if (obs_timeout) begin bad++; $display("FAIL bubbles_timeout: got no res_valid expected res_valid"); end
        total++; if (obs_ce_p != 3) begin bad++; $display("FAIL bubbles_ce_p: got %0d expected 3", obs_ce_p); end
        total++; if (obs_ce_m != 3) begin bad++; $display("FAIL bubbles_ce_m: got %0d expected 3", obs_ce_m); end
        for (int i = 0; i < 3; i++) begin
            logic [7:0] e0;
            e0 = (i == 0) ? 8'h01 : 8'h09;
            total++; if (i >= obs_op0.size() || obs_op0[i] !== e0) begin
                bad++; $display("FAIL bubbles_opmode[%0d]: got %h expected %h", i, (i < obs_op0.size()) ? obs_op0[i] : 8'hxx, e0);
            end
        end
        total++; if (obs_p0 !== exp0) begin bad++; $display("FAIL bubbles_p: got %0d expected %0d", obs_p0, exp0); end
        ack_result();
    endtask

    task automatic test_post_sub();
        ops_a[0] = 18'd10; ops_b[0] = 18'd1;
        ops_a[1] = 18'd2;  ops_b[1] = 18'd1;
        ops_a[2] = 18'd1;  ops_b[2] = 18'd3;
        run_job(3, 1);
        total++; if (obs_op1.size() != 3) begin bad++; $display("FAIL postsub_ce_p: got %0d expected 3", obs_op1.size()); end
        for (int i = 0; i < 3; i++) begin
            logic [7:0] e1;
            e1 = (i == 0) ? 8'h01 : 8'h89;
            total++; if (i >= obs_op1.size() || obs_op1[i] !== e1) begin
                bad++; $display("FAIL postsub_opmode[%0d]: got %h expected %h", i, (i < obs_op1.size()) ? obs_op1[i] : 8'hxx, e1);
            end
        end
        total++; if (obs_p1 !== 48'd5) begin bad++; $display("FAIL postsub_p: got %0d expected 5", obs_p1); end
        total++; if (obs_p0 !== 48'd15) begin bad++; $display("FAIL postsub_p_add: got %0d expected 15", obs_p0); end
        ack_result();
    endtask

    task automatic test_len_zero();
        run_job(0, 0);
        total++; if (obs_pclr_cnt != 1) begin bad++; $display("FAIL len0_pclr_count: got %0d expected 1", obs_pclr_cnt); end
        total++; if (obs_pclr_cyc != 1) begin bad++; $display("FAIL len0_pclr_cycle: got %0d expected 1", obs_pclr_cyc); end
        total++; if (obs_res_cyc != 2) begin bad++; $display("FAIL len0_res_cycle: got %0d expected 2", obs_res_cyc); end
        total++; if (obs_ce_ab + obs_ce_m + obs_ce_p != 0) begin
            bad++; $display("FAIL len0_no_ce: got %0d expected 0", obs_ce_ab + obs_ce_m + obs_ce_p);
        end
        total++; if (obs_p0 !== 48'd0) begin bad++; $display("FAIL len0_p: got %0d expected 0", obs_p0); end
        ack_result();
    endtask

    task automatic test_hold();
        ops_a[0] = 18'd4; ops_b[0] = 18'd4;
        ops_a[1] = 18'd2; ops_b[1] = 18'd6;
        run_job(2, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            res_ready = 1'b0;
            in_valid = 1'b1;
            start = (c == 2);
            len = 16'd7;
            #1;
            total++; if (res_valid[0] !== 1'b1 || busy[0] !== 1'b1) begin
                bad++; $display("FAIL hold_valid_busy[%0d]: got %b%b expected 11", c, res_valid[0], busy[0]);
            end
            total++; if ({ce_ab[0], ce_m[0], ce_p[0]} !== 3'b000) begin
                bad++; $display("FAIL hold_ce[%0d]: got %b expected 000", c, {ce_ab[0], ce_m[0], ce_p[0]});
            end
        end
        start = 1'b0; in_valid = 1'b0;
        total++; if (p_reg[0] !== 48'd28) begin bad++; $display("FAIL hold_p: got %0d expected 28", p_reg[0]); end
        ack_result();
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL hold_busy_after: got %b expected 0", busy[0]); end
        total++; if (sample_cnt[0] !== 16'd2) begin bad++; $display("FAIL hold_start_ignored: got %0d expected 2", sample_cnt[0]); end
    endtask

    task automatic test_reset_mid();
        logic [47:0] exp0;
        @(negedge clk); start = 1'b1; len = 16'd6; in_valid = 1'b0;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; a_in = 18'd100; b_in = 18'd100;
        @(negedge clk); a_in = 18'd200; b_in = 18'd200;
        @(negedge clk); rst = 1'b1; a_in = 18'd300;
        #1;
        total++; if ({busy[0], in_ready[0], ce_ab[0], ce_m[0], ce_p[0], p_clr[0], res_valid[0]} !== 7'b0) begin
            bad++; $display("FAIL midrst_ctrl: got %b expected 0000000",
                            {busy[0], in_ready[0], ce_ab[0], ce_m[0], ce_p[0], p_clr[0], res_valid[0]});
        end
        total++; if (opmode[0] !== 8'h00) begin bad++; $display("FAIL midrst_opmode: got %h expected 00", opmode[0]); end
        total++; if (sample_cnt[0] !== 16'd0) begin bad++; $display("FAIL midrst_sample_cnt: got %0d expected 0", sample_cnt[0]); end
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
        ops_a[0] = 18'd11; ops_b[0] = 18'd3;
        ops_a[1] = 18'd5;  ops_b[1] = 18'd2;
        exp0 = 48'd43;
        run_job(2, 0);
        total++; if (obs_ce_p != 2) begin bad++; $display("FAIL midrst_ce_p: got %0d expected 2", obs_ce_p); end
        total++; if (obs_op0.size() == 0 || obs_op0[0] !== 8'h01) begin
            bad++; $display("FAIL midrst_first_opmode: got %h expected 01", (obs_op0.size() > 0) ? obs_op0[0] : 8'hxx);
        end
        total++; if (obs_p0 !== exp0) begin bad++; $display("FAIL midrst_p: got %0d expected %0d", obs_p0, exp0); end
        ack_result();
    endtask

    task automatic test_random();
        res_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            int n, gap;
            logic [47:0] exp0, exp1;
            n = int'($urandom_range(1, 8));
            gap = int'($urandom_range(0, 2));
            exp0 = '0; exp1 = '0;
            for (int i = 0; i < n; i++) begin
                ops_a[i] = 18'($urandom_range(0, 5000));
                ops_b[i] = 18'($urandom_range(0, 5000));
                exp0 += 48'(ops_a[i]) * 48'(ops_b[i]);
                if (i == 0) exp1 = 48'(ops_a[i]) * 48'(ops_b[i]);
                else        exp1 -= 48'(ops_a[i]) * 48'(ops_b[i]);
            end
            run_job(n, gap);
            total++; if (obs_p0 !== exp0) begin bad++; $display("FAIL rand%0d_p: got %0d expected %0d", j, obs_p0, exp0); end
            total++; if (obs_p1 !== exp1) begin bad++; $display("FAIL rand%0d_p_sub: got %h expected %h", j, obs_p1, exp1); end
            total++; if (obs_ce_p != n) begin bad++; $display("FAIL rand%0d_ce_p: got %0d expected %0d", j, obs_ce_p, n); end
            total++; if (obs_res_cyc - obs_last_acc != 3) begin
                bad++; $display("FAIL rand%0d_latency: got %0d expected 3", j, obs_res_cyc - obs_last_acc);
            end
            // res_ready already high: handshake completes in the res_valid cycle.
            @(negedge clk); #1;
            total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL rand%0d_busy_after: got %b expected 0", j, busy[0]); end
        end
        res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubbles();
        test_post_sub();
        test_len_zero();
        test_hold();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
